hazard_controller: RTL and testbench



---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_controller.sv | 144 ++++++++++++++
 tb/tb_hazard_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: definitions shared by the pipeline hazard controller.
//   state_t  - sequencing FSM encoding (RUN, STALL, FREEZE)
//   REG_ZERO - architectural register $0; it never carries a dependency
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk   - system clock
//   clear - synchronous clear (takes precedence over inc)
//   inc   - count this cycle
//   count - current value, CNT_W bits
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage MIPS-style CPU.
// Inserts bubbles for hazards forwarding cannot cover (load-use, jr/jalr on a
// pending load), flushes on taken branches and jumps, freezes the back end
// while data memory is busy, and counts cycles in which the PC is held.
//   clk, reset               - clock, synchronous active-high reset
//   IF_ID_Rs/Rt, ID_uses_Rt  - source registers of the instruction in ID
//   ID_JumpReg, ID_Jump      - jr/jalr resp. j/jal in ID
//   ID_EX_*                  - load flag, write flag, destination of EX instr
//   EX_MEM_*                 - load flag and destination of MEM instr
//   EX_Branch_taken          - branch resolved taken in EX
//   mem_busy                 - data memory not ready this cycle
//   PC_Write, IF_ID_Write    - front-end enables
//   IF_ID_Flush, ID_EX_Flush - turn the register into a nop/bubble
//   Pipe_Freeze              - hold ID/EX, EX/MEM and MEM/WB
//   stall_cycles             - saturating count of cycles with PC_Write=0
import hazard_pkg::*;

module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             ID_JumpReg,
  input  logic             ID_Jump,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_Write_register,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_Write_register,
  input  logic             EX_Branch_taken,
  input  logic             mem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t     state, state_nxt, eff_state;
  logic [1:0] cnt, cnt_nxt, saved_cnt, saved_nxt, eff_cnt;
  logic       ex_hit_rs, ex_hit_rt, load_use, jr_ld_ex, jr_ld_mem, bubble;

  // ALU results reach jr through forwarding, so a plain register write in EX
  // never causes a stall on its own.
  logic unused_regwrite;
  assign unused_regwrite = ID_EX_RegWrite;

  assign ex_hit_rs = (ID_EX_Write_register != REG_ZERO) &&
                     (ID_EX_Write_register == IF_ID_Rs);
  assign ex_hit_rt = (ID_EX_Write_register != REG_ZERO) && ID_uses_Rt &&
                     (ID_EX_Write_register == IF_ID_Rt);
  assign load_use  = ID_EX_MemRead && (ex_hit_rs || ex_hit_rt);
  assign jr_ld_ex  = ID_JumpReg && ID_EX_MemRead && ex_hit_rs;
  assign jr_ld_mem = ID_JumpReg && EX_MEM_MemRead &&
                     (EX_MEM_Write_register != REG_ZERO) &&
                     (EX_MEM_Write_register == IF_ID_Rs);

  always_comb begin
    // While frozen, the cycle in which mem_busy drops is evaluated as if we
    // were already back in the interrupted state, so no extra cycle is lost.
    eff_state = state;
    eff_cnt   = cnt;
    if (state == FREEZE) begin
      eff_cnt   = saved_cnt;
      eff_state = (saved_cnt != 2'd0) ? STALL : RUN;
    end

    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    bubble      = 1'b0;
    state_nxt   = RUN;
    cnt_nxt     = 2'd0;
    saved_nxt   = 2'd0;

    if (mem_busy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
      state_nxt   = FREEZE;
      cnt_nxt     = cnt;
      saved_nxt   = (eff_state == STALL) ? eff_cnt : 2'd0;
    end else if (EX_Branch_taken) begin
      // Wrong-path instructions in IF and ID are squashed; pending stall dies.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (eff_state == STALL) begin
      bubble    = 1'b1;
      cnt_nxt   = eff_cnt - 2'd1;
      state_nxt = (eff_cnt == 2'd1) ? RUN : STALL;
    end else if (jr_ld_ex) begin
      // Load data reaches jr only after MEM: bubble now plus one more.
      bubble    = 1'b1;
      state_nxt = STALL;
      cnt_nxt   = 2'd1;
    end else if (jr_ld_mem || load_use) begin
      bubble = 1'b1;
    end

    if (bubble) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end

    if (ID_Jump && !mem_busy && !bubble) begin
      IF_ID_Flush = 1'b1;
    end

    if (reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      Pipe_Freeze = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= 2'd0;
      saved_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      saved_cnt <= saved_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (!PC_Write),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Write_register, EX_MEM_Write_register;
  logic ID_uses_Rt, ID_JumpReg, ID_Jump, ID_EX_MemRead, ID_EX_RegWrite;
  logic EX_MEM_MemRead, EX_Branch_taken, mem_busy;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze;
  logic [CNT_W-1:0] stall_cycles;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .IF_ID_Rs              (IF_ID_Rs),
    .IF_ID_Rt              (IF_ID_Rt),
    .ID_uses_Rt            (ID_uses_Rt),
    .ID_JumpReg            (ID_JumpReg),
    .ID_Jump               (ID_Jump),
    .ID_EX_MemRead         (ID_EX_MemRead),
    .ID_EX_RegWrite        (ID_EX_RegWrite),
    .ID_EX_Write_register  (ID_EX_Write_register),
    .EX_MEM_MemRead        (EX_MEM_MemRead),
    .EX_MEM_Write_register (EX_MEM_Write_register),
    .EX_Branch_taken       (EX_Branch_taken),
    .mem_busy              (mem_busy),
    .PC_Write              (PC_Write),
    .IF_ID_Write           (IF_ID_Write),
    .IF_ID_Flush           (IF_ID_Flush),
    .ID_EX_Flush           (ID_EX_Flush),
    .Pipe_Freeze           (Pipe_Freeze),
    .stall_cycles          (stall_cycles)
  );

  typedef struct {
    string            name;
    logic [4:0]       ctrl;  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze}
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cnt_m = 0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze} !== mon_e.ctrl) begin
        failures++;
        $display("FAIL %s ctrl(pcw,ifw,iff,idf,frz) got %b required %b", mon_e.name,
                 {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze}, mon_e.ctrl);
      end
      checks++;
      if (stall_cycles !== mon_e.cnt) begin
        failures++;
        $display("FAIL %s stall_cycles got %0d required %0d", mon_e.name, stall_cycles, mon_e.cnt);
      end
    end
  end

  task automatic idle();
    reset = 1'b0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_uses_Rt = 1'b0;
    ID_JumpReg = 1'b0; ID_Jump = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0;
    ID_EX_Write_register = 5'd0; EX_MEM_MemRead = 1'b0; EX_MEM_Write_register = 5'd0;
    EX_Branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Push the hand-computed outputs for the inputs currently driven, then
  // advance one clock. The counter expectation follows the expected PC_Write.
  task automatic cyc(input string name, input logic [4:0] ctrl);
    exp_t e;
    e.name = name;
    e.ctrl = ctrl;
    e.cnt  = CNT_W'(cnt_m);
    q.push_back(e);
    if (reset) cnt_m = 0;
    else if (!ctrl[4] && cnt_m < CNT_MAX) cnt_m++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] BUBL = 5'b00010;
  localparam logic [4:0] FRZ  = 5'b00001;
  localparam logic [4:0] BRF  = 5'b11110;
  localparam logic [4:0] RSTV = 5'b00110;
  localparam logic [4:0] JMPF = 5'b11100;

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_a", RSTV);
    cyc("reset_b", RSTV);
    idle();                                   cyc("idle", NORM);

    // load-use through rs, then through rt
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Write_register = 8; IF_ID_Rs = 8;
    cyc("lu_rs", BUBL);
    idle();                                   cyc("lu_rs_after", NORM);
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Write_register = 9; IF_ID_Rt = 9; ID_uses_Rt = 1;
    cyc("lu_rt", BUBL);
    ID_uses_Rt = 0;                           cyc("lu_rt_unused", NORM);

    // jr after load in EX: two bubbles
    idle(); ID_JumpReg = 1; IF_ID_Rs = 31; ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Write_register = 31;
    cyc("jr_ld_ex_1", BUBL);
    idle(); ID_JumpReg = 1; IF_ID_Rs = 31;    cyc("jr_ld_ex_2", BUBL);
    cyc("jr_ld_ex_done", NORM);

    // jr after ALU write: forwarded, no stall
    ID_EX_RegWrite = 1; ID_EX_Write_register = 31;
    cyc("jr_alu", NORM);
    // jr after load in MEM only: one bubble
    idle(); ID_JumpReg = 1; IF_ID_Rs = 31; EX_MEM_MemRead = 1; EX_MEM_Write_register = 31;
    cyc("jr_ld_mem", BUBL);
    EX_MEM_MemRead = 0;                       cyc("jr_ld_mem_done", NORM);

    // jumps
    idle(); ID_Jump = 1;                      cyc("jump", JMPF);
    ID_EX_MemRead = 1; ID_EX_Write_register = 4; IF_ID_Rs = 4;
    cyc("jump_stalled", BUBL);
    idle();                                   cyc("jump_after", NORM);

    // branch cancels a pending STALL
    ID_JumpReg = 1; IF_ID_Rs = 31; ID_EX_MemRead = 1; ID_EX_Write_register = 31;
    cyc("br_stall_enter", BUBL);
    idle(); ID_JumpReg = 1; IF_ID_Rs = 31; EX_Branch_taken = 1;
    cyc("br_in_stall", BRF);
    idle();                                   cyc("br_stall_after", NORM);

    // branch and load-use together: branch wins
    ID_EX_MemRead = 1; ID_EX_Write_register = 8; IF_ID_Rs = 8; EX_Branch_taken = 1;
    cyc("br_and_lu", BRF);
    idle();                                   cyc("br_and_lu_after", NORM);

    reset = 1;                                cyc("reset_clr", RSTV);

    // memory wait during STALL(cnt=1)
    idle(); ID_JumpReg = 1; IF_ID_Rs = 31; ID_EX_MemRead = 1; ID_EX_Write_register = 31;
    cyc("frz_stall_enter", BUBL);
    idle(); mem_busy = 1;
    for (int i = 0; i < 3; i++) cyc("frz_hold", FRZ);
    mem_busy = 0;                             cyc("frz_resume_bubble", BUBL);
    cyc("frz_done", NORM);

    // memory wait from RUN; release cycle sees a load-use normally
    mem_busy = 1; EX_Branch_taken = 1;        cyc("frz_over_branch", FRZ);
    idle(); ID_EX_MemRead = 1; ID_EX_Write_register = 5; IF_ID_Rs = 5;
    cyc("frz_release_lu", BUBL);
    idle();                                   cyc("frz_release_after", NORM);

    // register zero never stalls
    ID_EX_MemRead = 1; ID_EX_Write_register = 0; IF_ID_Rs = 0; IF_ID_Rt = 0; ID_uses_Rt = 1;
    cyc("zero_lu", NORM);
    ID_JumpReg = 1; ID_uses_Rt = 0;           cyc("zero_jr_ex", NORM);
    idle(); ID_JumpReg = 1; EX_MEM_MemRead = 1; EX_MEM_Write_register = 0;
    cyc("zero_jr_mem", NORM);

    // reset while frozen with a saved countdown
    idle(); ID_JumpReg = 1; IF_ID_Rs = 31; ID_EX_MemRead = 1; ID_EX_Write_register = 31;
    cyc("rf_stall_enter", BUBL);
    idle(); mem_busy = 1;                     cyc("rf_freeze", FRZ);
    reset = 1;                                cyc("rf_reset", RSTV);
    idle();                                   cyc("rf_after_1", NORM);
    cyc("rf_after_2", NORM);

    // counter saturation
    mem_busy = 1;
    for (int i = 0; i < CNT_MAX + 3; i++) cyc("sat_freeze", FRZ);
    idle();                                   cyc("sat_hold", NORM);
    cyc("sat_hold_2", NORM);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
